// File: rtl/usb_pll_pkg.sv
// ---------------------------------------------------------------------------
// usb_pll_pkg : shared state encoding and width helpers for the USB PLL supervisor
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package usb_pll_pkg;

  typedef enum logic [2:0] {
    ST_RST_PLL   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } pll_state_t;

  localparam int RETRY_W = 4;

  // Timers are loaded with (cycles - 1), so clog2 of the largest count suffices.
  function automatic int tmr_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

  localparam int TMR_W = tmr_width(20, 20000, 2000);

endpackage

`default_nettype wire

// File: rtl/usb_sync2.sv
// ---------------------------------------------------------------------------
// usb_sync2 : two-flop synchronizer, asynchronous active-low reset
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module usb_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/usb_pll_supervisor.sv
// ---------------------------------------------------------------------------
// usb_pll_supervisor : PLL reset/lock sequencer with bounded retry and fault latch
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module usb_pll_supervisor
  import usb_pll_pkg::*;
#(
  parameter int RST_CYCLES    = 20,
  parameter int LOCK_TIMEOUT  = 20000,
  parameter int STABLE_CYCLES = 2000,
  parameter int MAX_RETRY     = 4,
  parameter int CNT_W         = 8
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               pll_locked,
  input  logic               force_relock,
  output logic               pll_rst,
  output logic               usb_rst_req,
  output logic               lock_ok,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [CNT_W-1:0]   loss_cnt,
  output logic [2:0]         state_o
);

  localparam int TMR_WIDTH = tmr_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

  localparam logic [TMR_WIDTH-1:0] RST_LOAD    = TMR_WIDTH'(RST_CYCLES - 1);
  localparam logic [TMR_WIDTH-1:0] LOCK_LOAD   = TMR_WIDTH'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_WIDTH-1:0] STABLE_LOAD = TMR_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0]   RETRY_LIMIT = RETRY_W'(MAX_RETRY);

  pll_state_t           state, nxt_state;
  logic [TMR_WIDTH-1:0] timer, nxt_timer;
  logic [RETRY_W-1:0]   nxt_retry, retry_inc;
  logic [CNT_W-1:0]     nxt_loss;
  logic                 lk_s;
  logic                 attempt_failed;

  usb_sync2 #(.RST_VAL(1'b0)) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lk_s)
  );

  assign retry_inc = retry_cnt + 1'b1;
  assign state_o   = state;

  always_comb begin
    nxt_state      = state;
    nxt_timer      = (timer != '0) ? timer - 1'b1 : timer;
    nxt_retry      = retry_cnt;
    nxt_loss       = loss_cnt;
    attempt_failed = 1'b0;

    case (state)
      ST_RST_PLL: begin
        if (timer == '0) begin
          nxt_state = ST_WAIT_LOCK;
          nxt_timer = LOCK_LOAD;
        end
      end
      ST_WAIT_LOCK: begin
        if (lk_s) begin
          nxt_state = ST_STABLE;
          nxt_timer = STABLE_LOAD;
        end else if (timer == '0) begin
          attempt_failed = 1'b1;
        end
      end
      ST_STABLE: begin
        // A drop always wins over a coincident timer expiry.
        if (!lk_s) begin
          attempt_failed = 1'b1;
        end else if (timer == '0) begin
          nxt_state = ST_RUN;
          nxt_timer = '0;
          nxt_retry = '0;
        end
      end
      ST_RUN: begin
        if (!lk_s) begin
          if (loss_cnt != '1) nxt_loss = loss_cnt + 1'b1;
          nxt_state = ST_RST_PLL;
          nxt_timer = RST_LOAD;
        end
      end
      ST_FAULT: begin
        nxt_timer = '0;
      end
      default: begin
        nxt_state = ST_RST_PLL;
        nxt_timer = RST_LOAD;
      end
    endcase

    if (attempt_failed) begin
      nxt_retry = retry_inc;
      if (retry_inc == RETRY_LIMIT) begin
        nxt_state = ST_FAULT;
        nxt_timer = '0;
      end else begin
        nxt_state = ST_RST_PLL;
        nxt_timer = RST_LOAD;
      end
    end

    // Software restart overrides everything except the loss count bump above.
    if (force_relock) begin
      nxt_state = ST_RST_PLL;
      nxt_timer = RST_LOAD;
      nxt_retry = '0;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RST_PLL;
      timer       <= RST_LOAD;
      retry_cnt   <= '0;
      loss_cnt    <= '0;
      pll_rst     <= 1'b1;
      usb_rst_req <= 1'b1;
      lock_ok     <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= nxt_state;
      timer       <= nxt_timer;
      retry_cnt   <= nxt_retry;
      loss_cnt    <= nxt_loss;
      pll_rst     <= (nxt_state == ST_RST_PLL) || (nxt_state == ST_FAULT);
      usb_rst_req <= (nxt_state != ST_RUN);
      lock_ok     <= (nxt_state == ST_RUN);
      fault       <= (nxt_state == ST_FAULT);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_usb_pll_supervisor.sv
// ---------------------------------------------------------------------------
// tb_usb_pll_supervisor : directed self-checking bench for usb_pll_supervisor
// Revision              : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_usb_pll_supervisor;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       force_relock;
  logic       pll_rst;
  logic       usb_rst_req;
  logic       lock_ok;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 refclk = ~refclk;

  usb_pll_supervisor #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (50),
    .STABLE_CYCLES (10),
    .MAX_RETRY     (2),
    .CNT_W         (8)
  ) dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .force_relock (force_relock),
    .pll_rst      (pll_rst),
    .usb_rst_req  (usb_rst_req),
    .lock_ok      (lock_ok),
    .fault        (fault),
    .retry_cnt    (retry_cnt),
    .loss_cnt     (loss_cnt),
    .state_o      (state_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int limit, output int n);
    n = 0;
    while (state_o !== s && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_rst(input logic v, input int limit, output int n);
    n = 0;
    while (pll_rst !== v && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic loss_and_relock();
    int n;
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    wait_state(3'd0, 10, n);
    wait_state(3'd3, 100, n);
  endtask

  initial begin
    int n;
    int bad;

    rst_n        = 1'b1;
    pll_locked   = 1'b0;
    force_relock = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) tick();

    check("rst_state",   state_o,     0);
    check("rst_pll_rst", pll_rst,     1);
    check("rst_usb_req", usb_rst_req, 1);
    check("rst_lock_ok", lock_ok,     0);
    check("rst_fault",   fault,       0);
    check("rst_retry",   retry_cnt,   0);
    check("rst_loss",    loss_cnt,    0);

    // Normal lock: locked rises 20 cycles after pll_rst falls.
    rst_n = 1'b1;
    wait_rst(1'b0, 100, n);
    check("pll_rst_pulse", n, 4);
    repeat (20) tick();
    pll_locked = 1'b1;
    wait_state(3'd3, 100, n);
    check("lock_latency", n, 13);
    check("run_usb_req",  usb_rst_req, 0);
    check("run_lock_ok",  lock_ok,     1);
    check("run_retry",    retry_cnt,   0);

    // One-cycle lock loss in RUN.
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    wait_state(3'd0, 10, n);
    check("loss_latency", n + 1, 3);
    check("loss_usb_req", usb_rst_req, 1);
    check("loss_cnt_1",   loss_cnt,    1);
    wait_state(3'd3, 100, n);
    check("relock_lock_ok", lock_ok, 1);

    // Chatter during STABLE.
    pll_locked = 1'b0;
    wait_state(3'd0, 10, n);
    wait_rst(1'b0, 20, n);
    repeat (5) tick();
    pll_locked = 1'b1;
    wait_state(3'd2, 20, n);
    check("chat_to_stable", n, 3);
    repeat (5) tick();
    pll_locked = 1'b0;
    bad = 0;
    repeat (3) begin
      tick();
      if (usb_rst_req !== 1'b1) bad++;
    end
    pll_locked = 1'b1;
    check("chat_state",   state_o,   0);
    check("chat_retry",   retry_cnt, 1);
    check("chat_usb_req", bad,       0);
    wait_state(3'd3, 100, n);
    check("chat_relock_retry", retry_cnt, 0);
    check("loss_cnt_2",        loss_cnt,  2);

    // Lock timeout, retry, then fault.
    pll_locked = 1'b0;
    wait_state(3'd0, 10, n);
    wait_rst(1'b0, 20, n);
    wait_rst(1'b1, 100, n);
    check("timeout_1_len", n, 50);
    check("timeout_1_retry", retry_cnt, 1);
    check("timeout_1_state", state_o,   0);
    wait_rst(1'b0, 20, n);
    check("retry_pulse", n, 4);
    wait_rst(1'b1, 100, n);
    check("timeout_2_len",   n,         50);
    check("fault_state",     state_o,   4);
    check("fault_flag",      fault,     1);
    check("fault_retry",     retry_cnt, 2);
    bad = 0;
    repeat (1000) begin
      tick();
      if (pll_rst !== 1'b1 || fault !== 1'b1) bad++;
    end
    check("fault_hold", bad, 0);

    // force_relock out of FAULT.
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    check("force_fault",   fault,     0);
    check("force_retry",   retry_cnt, 0);
    check("force_state",   state_o,   0);
    check("force_pll_rst", pll_rst,   1);
    wait_rst(1'b0, 20, n);
    check("force_pulse", n, 4);
    repeat (20) tick();
    pll_locked = 1'b1;
    wait_state(3'd3, 100, n);
    check("force_lock_latency", n, 13);
    check("force_lock_ok", lock_ok,  1);
    check("loss_cnt_3",    loss_cnt, 3);

    // Repeated losses saturate the counter.
    for (int i = 0; i < 300; i++) loss_and_relock();
    check("loss_sat",       loss_cnt, 255);
    check("loss_sat_state", state_o,  3);

    // Asynchronous reset between edges while in STABLE.
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    wait_state(3'd2, 50, n);
    check("pre_areset_state", state_o, 2);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("areset_state",   state_o,     0);
    check("areset_pll_rst", pll_rst,     1);
    check("areset_usb_req", usb_rst_req, 1);
    check("areset_lock_ok", lock_ok,     0);
    check("areset_fault",   fault,       0);
    check("areset_retry",   retry_cnt,   0);
    check("areset_loss",    loss_cnt,    0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/usb_pll_supervisor.md
Name: usb_pll_supervisor

Overview:
- Supervises the USB 60 MHz clock PLL from the free-running 20 MHz reference domain.
- Drives the PLL `rst` input and consumes its asynchronous `locked` output.
- Deasserts the USB-domain reset request only after lock has been stable for a programmed time.
- Detects lock loss, retries relock a bounded number of times, then latches a fault until software forces a relock.

Parameters:
- RST_CYCLES, 20, refclk cycles pll_rst is held high per attempt (1 us at 20 MHz)
- LOCK_TIMEOUT, 20000, refclk cycles allowed for locked to rise after pll_rst release (1 ms)
- STABLE_CYCLES, 2000, consecutive synchronized-locked cycles required before RUN (100 us)
- MAX_RETRY, 4, failed attempts before FAULT; range 1..15
- CNT_W, 8, width of the saturating lock-loss counter

Ports:
- refclk  in  1  20 MHz reference clock; the only clock
- rst_n  in  1  asynchronous active-low reset
- pll_locked  in  1  PLL locked, asynchronous to refclk
- force_relock  in  1  single-cycle pulse: restart the sequence and clear fault
- pll_rst  out  1  to PLL rst, active high
- usb_rst_req  out  1  active high; the USB 60 MHz domain synchronizes it locally
- lock_ok  out  1  high only in RUN
- fault  out  1  high in FAULT
- retry_cnt  out  4  failed attempts since last RUN or force_relock
- loss_cnt  out  CNT_W  saturating count of lock losses while in RUN
- state_o  out  3  current state encoding, for debug

Behaviour:
- Clock and reset: one clock, refclk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - state = RST_PLL, timer = RST_CYCLES-1
  - pll_rst = 1, usb_rst_req = 1
  - lock_ok = 0, fault = 0
  - retry_cnt = 0, loss_cnt = 0
  - sync flops = 0
- Synchronization: pll_locked passes through a 2-flop synchronizer. lk_s is the synchronizer output, 2 refclk cycles of latency. Nothing else samples pll_locked.
- Outputs are registered and decoded from the next state, so they change in the same cycle the state register changes:
  - pll_rst = (state in {RST_PLL, FAULT})
  - usb_rst_req = (state != RUN)
  - lock_ok = (state == RUN)
  - fault = (state == FAULT)
- A single down-counting timer is reloaded on every state entry.
- States (3-bit encoding: RST_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4):
  - RST_PLL: timer counts down from RST_CYCLES-1. At 0 -> WAIT_LOCK, with timer = LOCK_TIMEOUT-1.
  - WAIT_LOCK: if lk_s = 1 -> STABLE, with timer = STABLE_CYCLES-1. Else, if timer = 0, this is a failed attempt: retry_cnt++, then -> FAULT if the new retry_cnt = MAX_RETRY, else -> RST_PLL.
  - STABLE: if lk_s = 0, failed attempt, handled exactly as the WAIT_LOCK timeout. Else, if timer = 0 -> RUN, with retry_cnt cleared. The lk_s check has priority over timer expiry.
  - RUN: if lk_s = 0: loss_cnt++ (saturates at all-ones, no wrap) -> RST_PLL, retry_cnt unchanged (0).
  - FAULT: holds pll_rst = 1 indefinitely. Leaves only on force_relock.
- force_relock:
  - In any state, takes priority over every transition: -> RST_PLL, retry_cnt = 0, fault clears next cycle.
  - If it coincides with lk_s = 0 in RUN, loss_cnt still increments.
  - loss_cnt is cleared only by rst_n.
- Minimum time from pll_rst release to usb_rst_req low: lock latency + 2 (synchronizer) + STABLE_CYCLES + 1.
- Reset mid-operation: rst_n low in any state returns all outputs asynchronously to their reset values; the sequence restarts from RST_PLL.
- Chattering pll_locked: each drop during STABLE consumes one retry, so the sequence cannot loop forever.

Decomposition:
- Shared package `usb_pll_pkg`:
  - state enum and its 3-bit encoding
  - timer width constant, TMR_W = clog2(max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES))
  - retry width constant (4)
- Sub-module `usb_sync2`: generic 2-flop synchronizer with async active-low reset. Reused for usb_rst_req in the 60 MHz domain.

Test Plan (sim overrides: RST_CYCLES=4, LOCK_TIMEOUT=50, STABLE_CYCLES=10, MAX_RETRY=2):
- Normal lock: release rst_n; pll_locked rises 20 cycles after pll_rst falls -> pll_rst high exactly 4 cycles; usb_rst_req falls 2+10+1 cycles after the locked edge; lock_ok=1; retry_cnt=0.
- Timeout retry: pll_locked held 0 -> pll_rst repulses after 50 WAIT cycles; retry_cnt=1, then 2 -> FAULT; fault=1, pll_rst=1 held 1000 cycles.
- Chatter in STABLE: drop pll_locked for 3 cycles at 5 cycles into STABLE -> retry_cnt=1, RST_PLL re-entered, usb_rst_req never falls.
- Lock loss in RUN: drop pll_locked 1 cycle -> usb_rst_req rises 3 cycles later; loss_cnt=1; relock completes to RUN; repeat 300 times -> loss_cnt saturates at 255.
- force_relock from FAULT: pulse -> fault=0 next cycle, retry_cnt=0, pll_rst held 4 cycles, normal lock reaches RUN.
- Async reset mid-STABLE: assert rst_n low between clock edges -> all outputs at reset values immediately, loss_cnt=0.
